// File: rtl/ppu_vram_arb_pkg.sv
// ppu_vram_arb_pkg: shared state encoding, owner IDs and VRAM bus widths for the VRAM arbiter
package ppu_vram_arb_pkg;
  localparam int AW = 14;
  localparam int DW = 8;
  typedef enum logic [1:0] {IDLE, ACC, WAIT} state_t;
  typedef enum logic [1:0] {OWN_BG = 2'd0, OWN_SPR = 2'd1, OWN_RI = 2'd2} owner_t;
endpackage

// File: rtl/ppu_vram_arb_rdpipe.sv
// ppu_vram_arb_rdpipe: RD_LAT-deep {valid, owner} line producing rd_d capture enable and per-owner rd_vld strobes
module ppu_vram_arb_rdpipe
  import ppu_vram_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       push_in,
  input  owner_t     own_in,
  output logic       cap_out,
  output logic [2:0] vld_out
);
  logic [RD_LAT-1:0] v;
  owner_t o [RD_LAT];
  assign cap_out = v[RD_LAT-1];
  // shift the read tag along with the VRAM latency; the owner strobe fires with the captured data
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      v <= '0;
      for (int i = 0; i < RD_LAT; i++) o[i] <= OWN_BG;
      vld_out <= 3'b000;
    end else begin
      v[0] <= push_in;
      o[0] <= own_in;
      for (int i = 1; i < RD_LAT; i++) begin
        v[i] <= v[i-1];
        o[i] <= o[i-1];
      end
      vld_out <= cap_out ? 3'b001 << o[RD_LAT-1] : 3'b000;
    end
endmodule

// File: rtl/ppu_vram_arb.sv
// ppu_vram_arb: single-port VRAM arbiter for BG/sprite/RI fetches; define PPU_VRAM_ARB_STATS_EN to add conflict_cnt_out
module ppu_vram_arb
  import ppu_vram_arb_pkg::*;
#(
  parameter int RD_LAT      = 1,
  parameter int RI_MAX_WAIT = 8
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          render_in,
  input  logic          bg_req_in,
  input  logic [AW-1:0] bg_a_in,
  output logic          bg_gnt_out,
  output logic          bg_rd_vld_out,
  input  logic          spr_req_in,
  input  logic [AW-1:0] spr_a_in,
  output logic          spr_gnt_out,
  output logic          spr_rd_vld_out,
  input  logic          ri_req_in,
  input  logic          ri_wr_in,
  input  logic [AW-1:0] ri_a_in,
  input  logic [DW-1:0] ri_d_in,
  output logic          ri_gnt_out,
  output logic          ri_rd_vld_out,
  output logic [DW-1:0] rd_d_out,
  output logic [AW-1:0] vram_a_out,
  output logic [DW-1:0] vram_d_out,
  output logic          vram_wr_out,
  input  logic [DW-1:0] vram_d_in,
  output logic          busy_out
`ifdef PPU_VRAM_ARB_STATS_EN
  ,
  output logic [15:0]   conflict_cnt_out
`endif
);
  localparam logic [7:0] MAX_W = 8'(RI_MAX_WAIT);
  state_t state, nxt;
  owner_t win;
  logic [2:0] req, gnt, rd_vld;
  logic [7:0] ri_cnt;
  logic [AW-1:0] win_a;
  logic sel_ok, go, win_wr, cap;
  assign {ri_gnt_out, spr_gnt_out, bg_gnt_out} = gnt;
  assign {ri_rd_vld_out, spr_rd_vld_out, bg_rd_vld_out} = rd_vld;
  assign busy_out = state != IDLE;
  // priority select and next state; the owner in its ACC cycle still shows a stale req, so it is masked
  always_comb begin
    req = {ri_req_in, spr_req_in, bg_req_in} & ~gnt;
    sel_ok = state == IDLE || (state == ACC && vram_wr_out) || (state == WAIT && |rd_vld);
    go = sel_ok && |req;
    win = (req[2] && (!render_in || ri_cnt == MAX_W)) ? OWN_RI : req[0] ? OWN_BG : req[1] ? OWN_SPR : OWN_RI;
    win_wr = win == OWN_RI && ri_wr_in;
    win_a = win == OWN_BG ? bg_a_in : win == OWN_SPR ? spr_a_in : ri_a_in;
    nxt = go ? ACC : ((state == ACC && !vram_wr_out) || (state == WAIT && !(|rd_vld))) ? WAIT : IDLE;
  end
  // state, grant strobes and registered VRAM bus / read data
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state <= IDLE;
      gnt <= 3'b000;
      vram_a_out <= '0;
      vram_d_out <= '0;
      vram_wr_out <= 1'b0;
      rd_d_out <= '0;
    end else begin
      state <= nxt;
      gnt <= go ? 3'b001 << win : 3'b000;
      vram_wr_out <= go && win_wr;
      if (go) vram_a_out <= win_a;
      if (go && win_wr) vram_d_out <= ri_d_in;
      if (cap) rd_d_out <= vram_d_in;
    end
  // RI starvation counter: counts pending cycles, saturates, clears when RI is granted
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) ri_cnt <= 8'd0;
    else ri_cnt <= ri_gnt_out ? 8'd0 : (ri_req_in && ri_cnt != MAX_W) ? ri_cnt + 8'd1 : ri_cnt;
  ppu_vram_arb_rdpipe #(.RD_LAT(RD_LAT)) u_rdpipe (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .push_in  (go && !win_wr),
    .own_in   (win),
    .cap_out  (cap),
    .vld_out  (rd_vld)
  );
`ifdef PPU_VRAM_ARB_STATS_EN
  // cycles in which some requester is pending without being granted
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) conflict_cnt_out <= 16'd0;
    else if (|req && conflict_cnt_out != 16'hffff) conflict_cnt_out <= conflict_cnt_out + 16'd1;
`endif
endmodule

// File: tb/tb_ppu_vram_arb.sv
// tb_ppu_vram_arb: scenario tasks plus randomized traffic checked against a transaction-level arbiter model
module tb_ppu_vram_arb;
  localparam int RD_LAT = 1;
  localparam int RI_MAX_WAIT = 8;
  logic clk_in = 1'b0;
  logic rst_n_in, render_in, bg_req_in, spr_req_in, ri_req_in, ri_wr_in;
  logic [13:0] bg_a_in, spr_a_in, ri_a_in, vram_a_out;
  logic [7:0] ri_d_in, rd_d_out, vram_d_out, vram_d_in;
  logic bg_gnt_out, bg_rd_vld_out, spr_gnt_out, spr_rd_vld_out, ri_gnt_out, ri_rd_vld_out;
  logic vram_wr_out, busy_out;
`ifdef PPU_VRAM_ARB_STATS_EN
  logic [15:0] conflict_cnt_out;
`endif
  logic [7:0] bus_mem [16384];
  logic [7:0] ref_mem [16384];
  logic [7:0] flags;
  int total = 0, bad = 0;
  int cyc = 0, free_at = 0, w = 0, rv_at = -1;
  logic [1:0] rv_own = 2'd0;
  logic [7:0] rv_dat = 8'd0, exp_d = 8'd0;
  logic [2:0] exp_gnt = 3'b000;
  logic [13:0] exp_a = 14'd0;
  logic exp_wr = 1'b0;

  ppu_vram_arb #(.RD_LAT(RD_LAT), .RI_MAX_WAIT(RI_MAX_WAIT)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .render_in(render_in),
    .bg_req_in(bg_req_in), .bg_a_in(bg_a_in), .bg_gnt_out(bg_gnt_out), .bg_rd_vld_out(bg_rd_vld_out),
    .spr_req_in(spr_req_in), .spr_a_in(spr_a_in), .spr_gnt_out(spr_gnt_out), .spr_rd_vld_out(spr_rd_vld_out),
    .ri_req_in(ri_req_in), .ri_wr_in(ri_wr_in), .ri_a_in(ri_a_in), .ri_d_in(ri_d_in),
    .ri_gnt_out(ri_gnt_out), .ri_rd_vld_out(ri_rd_vld_out), .rd_d_out(rd_d_out),
    .vram_a_out(vram_a_out), .vram_d_out(vram_d_out), .vram_wr_out(vram_wr_out),
    .vram_d_in(vram_d_in), .busy_out(busy_out)
`ifdef PPU_VRAM_ARB_STATS_EN
    , .conflict_cnt_out(conflict_cnt_out)
`endif
  );

  always #5 clk_in = ~clk_in;
  assign vram_d_in = bus_mem[vram_a_out];
  assign flags = {bg_gnt_out, spr_gnt_out, ri_gnt_out, bg_rd_vld_out, spr_rd_vld_out, ri_rd_vld_out, vram_wr_out, busy_out};

  initial begin
    for (int i = 0; i < 16384; i++) bus_mem[i] = 8'(i * 73 + i / 32);
    bus_mem[14'h23c0] = 8'h5a;
    forever begin
      @(posedge clk_in);
      if (vram_wr_out) bus_mem[vram_a_out] = vram_d_out;
    end
  end

  // one clock: sample point #1 after the edge; advances the arbiter model and retires granted requests
  task automatic tick();
    logic [2:0] rq, el, old;
    int win;
    @(posedge clk_in);
    #1;
    cyc++;
    old = exp_gnt;
    if (!rst_n_in) begin
      exp_gnt = 3'b000;
      exp_wr = 1'b0;
      free_at = 0;
      w = 0;
      rv_at = -1;
    end else begin
      rq = {ri_req_in, spr_req_in, bg_req_in};
      el = rq & ~old;
      win = -1;
      if (cyc >= free_at && el != 3'b000)
        win = (el[2] && (!render_in || w == RI_MAX_WAIT)) ? 2 : el[0] ? 0 : el[1] ? 1 : 2;
      if (old[2]) w = 0;
      else if (ri_req_in && w < RI_MAX_WAIT) w++;
      exp_gnt = 3'b000;
      exp_wr = 1'b0;
      if (win >= 0) begin
        exp_gnt[win] = 1'b1;
        exp_a = win == 0 ? bg_a_in : win == 1 ? spr_a_in : ri_a_in;
        exp_wr = win == 2 && ri_wr_in;
        if (exp_wr) begin
          exp_d = ri_d_in;
          ref_mem[exp_a] = ri_d_in;
          free_at = cyc + 1;
        end else begin
          rv_at = cyc + RD_LAT;
          rv_own = 2'(win);
          rv_dat = ref_mem[exp_a];
          free_at = cyc + RD_LAT + 1;
        end
      end
    end
    if (old[0]) bg_req_in = 1'b0;
    if (old[1]) spr_req_in = 1'b0;
    if (old[2]) ri_req_in = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (bg_req_in || spr_req_in || ri_req_in || busy_out); i++) tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    tick();
    tick();
    total++; if (flags !== 8'h00) begin bad++; $display("FAIL reset_flags got=%b want=00000000", flags); end
    total++; if (vram_a_out !== 14'h0) begin bad++; $display("FAIL reset_vram_a got=%h want=0000", vram_a_out); end
    total++; if ({vram_d_out, rd_d_out} !== 16'h0) begin bad++; $display("FAIL reset_data got=%h want=0000", {vram_d_out, rd_d_out}); end
    rst_n_in = 1'b1;
    tick();
    total++; if (flags !== 8'h00) begin bad++; $display("FAIL idle_flags got=%b want=00000000", flags); end
  endtask

  task automatic test_single_read();
    render_in = 1'b1;
    bg_a_in = 14'h23c0;
    bg_req_in = 1'b1;
    tick();
    total++; if (bg_gnt_out !== 1'b1) begin bad++; $display("FAIL sr_gnt got=%b want=1", bg_gnt_out); end
    total++; if (vram_a_out !== 14'h23c0) begin bad++; $display("FAIL sr_addr got=%h want=23c0", vram_a_out); end
    total++; if ({vram_wr_out, busy_out} !== 2'b01) begin bad++; $display("FAIL sr_wr_busy got=%b want=01", {vram_wr_out, busy_out}); end
    tick();
    total++; if ({bg_gnt_out, bg_rd_vld_out} !== 2'b01) begin bad++; $display("FAIL sr_vld got=%b want=01", {bg_gnt_out, bg_rd_vld_out}); end
    total++; if (rd_d_out !== 8'h5a) begin bad++; $display("FAIL sr_data got=%h want=5a", rd_d_out); end
    tick();
    total++; if ({bg_rd_vld_out, busy_out} !== 2'b00) begin bad++; $display("FAIL sr_after got=%b want=00", {bg_rd_vld_out, busy_out}); end
  endtask

  task automatic test_collision();
    int g[$];
    int r[$];
    logic [7:0] d[$];
    logic [7:0] want [3];
    render_in = 1'b1;
    bg_a_in = 14'h0100; spr_a_in = 14'h0200; ri_a_in = 14'h0300; ri_wr_in = 1'b0;
    want[0] = ref_mem[14'h0100]; want[1] = ref_mem[14'h0200]; want[2] = ref_mem[14'h0300];
    bg_req_in = 1'b1; spr_req_in = 1'b1; ri_req_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bg_gnt_out) g.push_back(0);
      if (spr_gnt_out) g.push_back(1);
      if (ri_gnt_out) g.push_back(2);
      if (bg_rd_vld_out) begin r.push_back(0); d.push_back(rd_d_out); end
      if (spr_rd_vld_out) begin r.push_back(1); d.push_back(rd_d_out); end
      if (ri_rd_vld_out) begin r.push_back(2); d.push_back(rd_d_out); end
    end
    total++; if (g.size() != 3 || r.size() != 3) begin bad++; $display("FAIL col_count got gnt=%0d vld=%0d want 3/3", g.size(), r.size()); end
    for (int i = 0; i < 3; i++) begin
      total++; if ((i < g.size() ? g[i] : -1) != i) begin bad++; $display("FAIL col_gnt_order[%0d] got=%0d want=%0d", i, i < g.size() ? g[i] : -1, i); end
      total++; if ((i < r.size() ? r[i] : -1) != i) begin bad++; $display("FAIL col_vld_order[%0d] got=%0d want=%0d", i, i < r.size() ? r[i] : -1, i); end
      total++; if ((i < d.size() ? d[i] : 8'hxx) !== want[i]) begin bad++; $display("FAIL col_data[%0d] got=%h want=%h", i, i < d.size() ? d[i] : 8'hxx, want[i]); end
    end
  endtask

  task automatic test_ri_starve();
    int k = 0;
    logic done = 1'b0;
    render_in = 1'b1;
    ri_wr_in = 1'b0; ri_a_in = 14'h0400; bg_a_in = 14'h0500;
    bg_req_in = 1'b1; ri_req_in = 1'b1;
    while (!done && k < 40) begin
      tick();
      k++;
      if (ri_gnt_out) done = 1'b1;
      if (!done) bg_req_in = 1'b1;
    end
    total++; if (!done) begin bad++; $display("FAIL starve_timeout got=no_gnt want=gnt"); end
    total++; if (k > RI_MAX_WAIT + RD_LAT + 1) begin bad++; $display("FAIL starve_latency got=%0d want<=%0d", k, RI_MAX_WAIT + RD_LAT + 1); end
    drain();
  endtask

  task automatic test_ri_write_vblank();
    logic seen = 1'b0;
    render_in = 1'b0;
    ri_wr_in = 1'b1; ri_a_in = 14'h2000; ri_d_in = 8'h41; bg_a_in = 14'h0600;
    ri_req_in = 1'b1; bg_req_in = 1'b1;
    tick();
    total++; if ({ri_gnt_out, bg_gnt_out, vram_wr_out} !== 3'b101) begin bad++; $display("FAIL wr_gnt got=%b want=101", {ri_gnt_out, bg_gnt_out, vram_wr_out}); end
    total++; if (vram_a_out !== 14'h2000) begin bad++; $display("FAIL wr_addr got=%h want=2000", vram_a_out); end
    total++; if (vram_d_out !== 8'h41) begin bad++; $display("FAIL wr_data got=%h want=41", vram_d_out); end
    tick();
    total++; if ({vram_wr_out, bg_gnt_out} !== 2'b01) begin bad++; $display("FAIL wr_b2b got=%b want=01", {vram_wr_out, bg_gnt_out}); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ri_rd_vld_out) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL wr_no_vld got=1 want=0"); end
    total++; if (bus_mem[14'h2000] !== 8'h41) begin bad++; $display("FAIL wr_mem got=%h want=41", bus_mem[14'h2000]); end
    ri_wr_in = 1'b0;
    render_in = 1'b1;
    drain();
  endtask

  task automatic test_reset_mid_read();
    logic seen = 1'b0;
    bg_a_in = 14'h0123;
    bg_req_in = 1'b1;
    tick();
    total++; if (bg_gnt_out !== 1'b1) begin bad++; $display("FAIL rmr_gnt got=%b want=1", bg_gnt_out); end
    #2;
    rst_n_in = 1'b0;
    bg_req_in = 1'b0;
    #1;
    total++; if (flags !== 8'h00) begin bad++; $display("FAIL rmr_flags got=%b want=00000000", flags); end
    total++; if ({vram_a_out, vram_d_out, rd_d_out} !== 30'h0) begin bad++; $display("FAIL rmr_regs got=%h want=0", {vram_a_out, vram_d_out, rd_d_out}); end
    tick();
    rst_n_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bg_rd_vld_out || busy_out) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL rmr_after got=activity want=none"); end
  endtask

  task automatic test_random();
    logic [2:0] g, rv, erv;
    for (int n = 0; n < 600; n++) begin
      tick();
      g = {ri_gnt_out, spr_gnt_out, bg_gnt_out};
      rv = {ri_rd_vld_out, spr_rd_vld_out, bg_rd_vld_out};
      erv = 3'b000;
      if (cyc == rv_at) erv[rv_own] = 1'b1;
      total++; if (g !== exp_gnt) begin bad++; $display("FAIL rnd_gnt cyc=%0d got=%b want=%b", cyc, g, exp_gnt); end
      total++; if (vram_wr_out !== exp_wr) begin bad++; $display("FAIL rnd_wr cyc=%0d got=%b want=%b", cyc, vram_wr_out, exp_wr); end
      if (exp_gnt != 3'b000) begin
        total++; if (vram_a_out !== exp_a) begin bad++; $display("FAIL rnd_addr cyc=%0d got=%h want=%h", cyc, vram_a_out, exp_a); end
      end
      if (exp_wr) begin
        total++; if (vram_d_out !== exp_d) begin bad++; $display("FAIL rnd_wdata cyc=%0d got=%h want=%h", cyc, vram_d_out, exp_d); end
      end
      total++; if (rv !== erv) begin bad++; $display("FAIL rnd_vld cyc=%0d got=%b want=%b", cyc, rv, erv); end
      if (erv != 3'b000) begin
        total++; if (rd_d_out !== rv_dat) begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h want=%h", cyc, rd_d_out, rv_dat); end
      end
      if ($urandom_range(0, 15) == 0) render_in = ~render_in;
      if (!bg_req_in && $urandom_range(0, 2) == 0) begin
        bg_req_in = 1'b1; bg_a_in = 14'h2000 | 14'($urandom_range(0, 15));
      end
      if (!spr_req_in && $urandom_range(0, 2) == 0) begin
        spr_req_in = 1'b1; spr_a_in = 14'h2000 | 14'($urandom_range(0, 15));
      end
      if (!ri_req_in && $urandom_range(0, 2) == 0) begin
        ri_req_in = 1'b1; ri_a_in = 14'h2000 | 14'($urandom_range(0, 15));
        ri_wr_in = 1'($urandom_range(0, 1)); ri_d_in = 8'($urandom);
      end
    end
    drain();
    ri_wr_in = 1'b0;
  endtask

`ifdef PPU_VRAM_ARB_STATS_EN
  task automatic test_stats();
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    tick();
    total++; if (conflict_cnt_out !== 16'd0) begin bad++; $display("FAIL stats_reset got=%0d want=0", conflict_cnt_out); end
    bg_a_in = 14'h0100; spr_a_in = 14'h0200; ri_a_in = 14'h0300; ri_wr_in = 1'b0;
    bg_req_in = 1'b1; spr_req_in = 1'b1; ri_req_in = 1'b1;
    repeat (12) tick();
    total++; if (conflict_cnt_out !== 16'd5) begin bad++; $display("FAIL stats_count got=%0d want=5", conflict_cnt_out); end
  endtask
`endif

  initial begin
    rst_n_in = 1'b0; render_in = 1'b1;
    bg_req_in = 1'b0; spr_req_in = 1'b0; ri_req_in = 1'b0; ri_wr_in = 1'b0;
    bg_a_in = 14'h0; spr_a_in = 14'h0; ri_a_in = 14'h0; ri_d_in = 8'h0;
    for (int i = 0; i < 16384; i++) ref_mem[i] = 8'(i * 73 + i / 32);
    ref_mem[14'h23c0] = 8'h5a;
    test_reset();
    test_single_read();
    drain();
    test_collision();
    drain();
    test_ri_starve();
    test_ri_write_vblank();
    test_reset_mid_read();
    test_random();
`ifdef PPU_VRAM_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
